// File: rtl/bsg_hash_bank_pkg.sv
// Shared types and helpers for the forward bank hash.
// Holds the FSM state encoding and parameter-time math helpers.
package bsg_hash_bank_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_busy,
    e_done
  } state_e;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int floor_log2(input int n);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++)
      if (n >= (1 << i)) r = i;
    return r;
  endfunction

endpackage

// File: rtl/bsg_hash_bank_divider.sv
// Iterative restoring divider: addr / banks_p, one quotient bit per step.
// rem_o/quot_o present the values this step will commit.
module bsg_hash_bank_divider
  import bsg_hash_bank_pkg::*;
#(
  parameter int banks_p = 3,
  parameter int width_p = 8,
  parameter int bank_width_lp = 2
)(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [width_p-1:0]     addr_i,
  input  logic                   step_i,
  output logic                   done_o,
  output logic [bank_width_lp:0] rem_o,
  output logic [width_p-1:0]     quot_o
);

  localparam int cnt_width_lp = (width_p > 1) ? $clog2(width_p) : 1;
  localparam logic [bank_width_lp:0] banks_lp =
    (bank_width_lp + 1)'(banks_p);

  logic [bank_width_lp:0]  rem_q, rem_d;
  logic [width_p-1:0]      quot_q, quot_d;
  logic [cnt_width_lp-1:0] cnt_q;
  logic [bank_width_lp:0]  trial;
  logic                    ge;

  // Remainder never exceeds banks_p-1, so its top bit is never shifted up.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[bank_width_lp];

  // One restoring step: shift in the quotient MSB, subtract if it fits.
  always_comb begin
    trial  = {rem_q[bank_width_lp-1:0], quot_q[width_p-1]};
    ge     = (trial >= banks_lp);
    rem_d  = ge ? (trial - banks_lp) : trial;
    quot_d = {quot_q[width_p-2:0], ge};
  end

  // Datapath registers: load on start, advance on step.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
    end else if (start_i) begin
      rem_q  <= '0;
      quot_q <= addr_i;
      cnt_q  <= cnt_width_lp'(width_p - 1);
    end else if (step_i) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_q - cnt_width_lp'(1);
    end
  end

  assign done_o = (cnt_q == '0);
  assign rem_o  = rem_d;
  assign quot_o = quot_d;

endmodule

// File: rtl/bsg_hash_bank_seq.sv
// Forward bank hash: addr -> (addr mod banks_p, addr / banks_p).
// Bit slicing for power-of-two banks, iterative divider otherwise.
module bsg_hash_bank_seq
  import bsg_hash_bank_pkg::*;
#(
  parameter int banks_p = 1,
  parameter int width_p = 32,
  localparam int bank_width_lp = (banks_p > 1) ? $clog2(banks_p) : 1,
  localparam int index_width_lp = width_p - floor_log2(banks_p)
)(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        addr_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [bank_width_lp-1:0]  bank_o,
  output logic [index_width_lp-1:0] index_o,
  input  logic                      yumi_i
);

  localparam bit pow2_lp  = is_pow2(banks_p);
  localparam int shift_lp = floor_log2(banks_p);

  state_e state_q, state_d;
  logic [bank_width_lp-1:0]  bank_q;
  logic [index_width_lp-1:0] index_q;
  logic [bank_width_lp-1:0]  res_bank;
  logic [index_width_lp-1:0] res_index;
  logic accept;
  logic load;
  logic div_done;

  assign ready_o = (state_q == e_idle)
                 | ((state_q == e_done) & yumi_i);
  assign accept  = v_i & ready_o;
  assign v_o     = (state_q == e_done);
  assign bank_o  = bank_q;
  assign index_o = index_q;

  if (pow2_lp) begin : g_pow2
    if (banks_p == 1) begin : g_one
      assign res_bank = '0;
    end else begin : g_many
      assign res_bank = addr_i[bank_width_lp-1:0];
    end
    assign res_index = addr_i[width_p-1:shift_lp];
    assign div_done  = 1'b0;
  end else begin : g_div
    logic [bank_width_lp:0] div_rem;
    logic [width_p-1:0]     div_quot;

    bsg_hash_bank_divider #(
      .banks_p       (banks_p),
      .width_p       (width_p),
      .bank_width_lp (bank_width_lp)
    ) divider (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .start_i (accept),
      .addr_i  (addr_i),
      .step_i  (state_q == e_busy),
      .done_o  (div_done),
      .rem_o   (div_rem),
      .quot_o  (div_quot)
    );

    // Quotient upper bits are zero since addr < 2^width_p.
    logic unused_div;
    assign unused_div =
      ^{div_rem[bank_width_lp], div_quot[width_p-1:index_width_lp]};

    assign res_bank  = div_rem[bank_width_lp-1:0];
    assign res_index = div_quot[index_width_lp-1:0];
  end

  // Next state and result-register load enable.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      e_idle, e_done: begin
        if (accept) begin
          state_d = pow2_lp ? e_done : e_busy;
          load    = pow2_lp;
        end else if ((state_q == e_done) && yumi_i) begin
          state_d = e_idle;
        end
      end
      e_busy: begin
        if (div_done) begin
          state_d = e_done;
          load    = 1'b1;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= e_idle;
    else         state_q <= state_d;
  end

  // Result registers: held until the next accept or division end.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bank_q  <= '0;
      index_q <= '0;
    end else if (load) begin
      bank_q  <= res_bank;
      index_q <= res_index;
    end
  end

  a_yumi_needs_v: assert property (
    @(posedge clk_i) disable iff (reset_i)
    yumi_i |-> v_o
  );

  a_addr_stable: assert property (
    @(posedge clk_i) disable iff (reset_i)
    (v_i && !ready_o) |=> (!v_i || $stable(addr_i))
  );

endmodule

// File: tb/tb_bsg_hash_bank_seq.sv
// Directed bench for bsg_hash_bank_seq across several bank counts.
// Uses one instance per (banks_p, width_p) configuration.
module tb_bsg_hash_bank_seq;

  localparam int N = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int banks_c [N] = '{1, 3, 4, 6, 12};
  int width_c [N] = '{32, 8, 8, 12, 16};
  int lat_c   [N] = '{1, 9, 1, 13, 17};

  logic [N-1:0] v;
  logic [N-1:0] yumi;
  logic [31:0]  addr [N];
  wire  [N-1:0] rdy;
  wire  [N-1:0] vo;
  wire  [31:0]  bank [N];
  wire  [31:0]  idx  [N];

  int n_checks = 0;
  int n_errors = 0;

  wire [0:0]  b0; wire [31:0] i0;
  wire [1:0]  b1; wire [6:0]  i1;
  wire [1:0]  b2; wire [5:0]  i2;
  wire [2:0]  b3; wire [9:0]  i3;
  wire [3:0]  b4; wire [12:0] i4;

  bsg_hash_bank_seq #(.banks_p(1), .width_p(32)) u0 (
    .clk_i(clk), .reset_i(reset), .v_i(v[0]), .addr_i(addr[0]),
    .ready_o(rdy[0]), .v_o(vo[0]), .bank_o(b0), .index_o(i0),
    .yumi_i(yumi[0]));
  bsg_hash_bank_seq #(.banks_p(3), .width_p(8)) u1 (
    .clk_i(clk), .reset_i(reset), .v_i(v[1]), .addr_i(addr[1][7:0]),
    .ready_o(rdy[1]), .v_o(vo[1]), .bank_o(b1), .index_o(i1),
    .yumi_i(yumi[1]));
  bsg_hash_bank_seq #(.banks_p(4), .width_p(8)) u2 (
    .clk_i(clk), .reset_i(reset), .v_i(v[2]), .addr_i(addr[2][7:0]),
    .ready_o(rdy[2]), .v_o(vo[2]), .bank_o(b2), .index_o(i2),
    .yumi_i(yumi[2]));
  bsg_hash_bank_seq #(.banks_p(6), .width_p(12)) u3 (
    .clk_i(clk), .reset_i(reset), .v_i(v[3]), .addr_i(addr[3][11:0]),
    .ready_o(rdy[3]), .v_o(vo[3]), .bank_o(b3), .index_o(i3),
    .yumi_i(yumi[3]));
  bsg_hash_bank_seq #(.banks_p(12), .width_p(16)) u4 (
    .clk_i(clk), .reset_i(reset), .v_i(v[4]), .addr_i(addr[4][15:0]),
    .ready_o(rdy[4]), .v_o(vo[4]), .bank_o(b4), .index_o(i4),
    .yumi_i(yumi[4]));

  assign bank[0] = 32'(b0); assign idx[0] = i0;
  assign bank[1] = 32'(b1); assign idx[1] = 32'(i1);
  assign bank[2] = 32'(b2); assign idx[2] = 32'(i2);
  assign bank[3] = 32'(b3); assign idx[3] = 32'(i3);
  assign bank[4] = 32'(b4); assign idx[4] = 32'(i4);

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  // From the negedge after the accepting edge, wait for v_o.
  // lat counts clock edges from the accepting edge inclusive.
  task automatic wait_vo(input int k, output int lat);
    lat = 1;
    while (!vo[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) check("vo_timeout", 64'(vo[k]), 64'd1);
  endtask

  task automatic run(input int k, input logic [31:0] a,
                     output logic [31:0] b, output logic [31:0] ix,
                     output int lat);
    int guard;
    @(negedge clk);
    v[k] = 1'b1;
    addr[k] = a;
    guard = 0;
    #1;
    while (!rdy[k] && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) check("ready_timeout", 64'(rdy[k]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    v[k] = 1'b0;
    wait_vo(k, lat);
    b = bank[k];
    ix = idx[k];
  endtask

  // Called at a negedge with v_o high: retire the result.
  task automatic retire(input int k);
    yumi[k] = 1'b1;
    @(negedge clk);
    yumi[k] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] b, ix, a, mask;
    int lat;
    v = '0;
    yumi = '0;
    for (int k = 0; k < N; k++) addr[k] = '0;

    // Reset state
    #1;
    check("rst_v", 64'(vo[1]), 64'd0);
    check("rst_bank", 64'(bank[1]), 64'd0);
    check("rst_index", 64'(idx[1]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", 64'(rdy[1]), 64'd1);

    // banks 3, addr 200 -> (2, 66), 9 cycles
    run(1, 32'd200, b, ix, lat);
    check("d3_200_bank", 64'(b), 64'd2);
    check("d3_200_index", 64'(ix), 64'd66);
    check("d3_200_lat", 64'(lat), 64'd9);
    retire(1);

    // banks 3, addr 255 held 5 cycles -> (0, 85)
    run(1, 32'd255, b, ix, lat);
    check("d3_255_bank", 64'(b), 64'd0);
    check("d3_255_index", 64'(ix), 64'd85);
    v[1] = 1'b1;
    addr[1] = 32'd100;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_ready", 64'(rdy[1]), 64'd0);
      check("hold_bank", 64'(bank[1]), 64'd0);
      check("hold_index", 64'(idx[1]), 64'd85);
      @(negedge clk);
    end
    yumi[1] = 1'b1;
    #1;
    check("b2b_ready", 64'(rdy[1]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    yumi[1] = 1'b0;
    v[1] = 1'b0;
    wait_vo(1, lat);
    check("b2b_bank", 64'(bank[1]), 64'd1);
    check("b2b_index", 64'(idx[1]), 64'd33);
    check("b2b_lat", 64'(lat), 64'd9);
    retire(1);

    // Reset in the 4th BUSY cycle
    @(negedge clk);
    v[1] = 1'b1;
    addr[1] = 32'd77;
    @(posedge clk);
    @(negedge clk);
    v[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_v", 64'(vo[1]), 64'd0);
    check("midrst_bank", 64'(bank[1]), 64'd0);
    check("midrst_index", 64'(idx[1]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_ready", 64'(rdy[1]), 64'd1);
    run(1, 32'd7, b, ix, lat);
    check("midrst_7_bank", 64'(b), 64'd1);
    check("midrst_7_index", 64'(ix), 64'd2);
    check("midrst_7_lat", 64'(lat), 64'd9);
    retire(1);

    // banks 1, width 32
    run(0, 32'hDEADBEEF, b, ix, lat);
    check("b1_bank", 64'(b), 64'd0);
    check("b1_index", 64'(ix), 64'hDEADBEEF);
    check("b1_lat", 64'(lat), 64'd1);
    retire(0);

    // banks 4 streaming with yumi tied to v_o
    @(negedge clk);
    v[2] = 1'b1;
    addr[2] = 32'hB7;
    @(negedge clk);
    check("s4_b7_v", 64'(vo[2]), 64'd1);
    check("s4_b7_bank", 64'(bank[2]), 64'd3);
    check("s4_b7_index", 64'(idx[2]), 64'd45);
    yumi[2] = 1'b1;
    addr[2] = 32'h00;
    @(negedge clk);
    check("s4_00_v", 64'(vo[2]), 64'd1);
    check("s4_00_bank", 64'(bank[2]), 64'd0);
    check("s4_00_index", 64'(idx[2]), 64'd0);
    addr[2] = 32'hFF;
    @(negedge clk);
    check("s4_ff_v", 64'(vo[2]), 64'd1);
    check("s4_ff_bank", 64'(bank[2]), 64'd3);
    check("s4_ff_index", 64'(idx[2]), 64'd63);
    v[2] = 1'b0;
    @(negedge clk);
    yumi[2] = 1'b0;
    check("s4_end_v", 64'(vo[2]), 64'd0);

    // Round trip: index*banks + bank must rebuild addr
    for (int k = 0; k < N; k++) begin
      mask = 32'((64'd1 << width_c[k]) - 64'd1);
      for (int i = 0; i < 200; i++) begin
        if (i == 0)      a = '0;
        else if (i == 1) a = mask;
        else             a = $urandom & mask;
        run(k, a, b, ix, lat);
        check("rt_addr",
              64'(ix) * 64'(banks_c[k]) + 64'(b), 64'(a));
        check("rt_bank_range",
              64'(b < 32'(banks_c[k])), 64'd1);
        check("rt_lat", 64'(lat), 64'(lat_c[k]));
        retire(k);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
